// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite register-file responder
// Purpose: two RW registers (CTRL, DATA) and two RO counters (WR_COUNT, RD_COUNT)
//          behind independent write and read channel FSMs.
// Optional feature: AXIL_REG_SLAVE_DECERR_EN makes unmapped accesses return DECERR.
// Ports:
//   s_axi_aclk, s_axi_aresetn   - clock, async active-low reset
//   s_axi_aw*/s_axi_w*/s_axi_b* - write address, write data, write response
//   s_axi_ar*/s_axi_r*          - read address, read data/response
//   ctrl_o                      - live CTRL register value
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   ctrl_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
`ifdef AXIL_REG_SLAVE_DECERR_EN
  localparam logic [RESP_WIDTH-1:0] RESP_UNMAPPED = RESP_WIDTH'(3);
`else
  localparam logic [RESP_WIDTH-1:0] RESP_UNMAPPED = RESP_WIDTH'(0);
`endif

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  // Holds the ready outputs low until the first edge after reset release.
  logic active_q, active_d;

  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] wr_count_q, wr_count_d;
  logic [DATA_WIDTH-1:0] rd_count_q, rd_count_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;

  function automatic logic addr_unmapped(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 4) != '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign s_axi_awready = active_q && (w_state_q == W_IDLE || w_state_q == W_DATA);
  assign s_axi_wready  = active_q && (w_state_q == W_IDLE || w_state_q == W_ADDR);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = active_q && (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ctrl_o        = ctrl_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  assign active_d = 1'b1;

  // Write channel: capture whichever of AW/W arrives first, commit on the second.
  always_comb begin
    w_state_d  = w_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    ctrl_d     = ctrl_q;
    data_d     = data_q;
    wr_count_d = wr_count_q;
    wr_fire    = 1'b0;
    wr_addr    = awaddr_q;
    wr_data    = wdata_q;
    wr_strb    = wstrb_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_fire = 1'b1;
          wr_addr = s_axi_awaddr;
          wr_data = s_axi_wdata;
          wr_strb = s_axi_wstrb;
        end else if (aw_hs) begin
          awaddr_d  = s_axi_awaddr;
          w_state_d = W_ADDR;
        end else if (w_hs) begin
          wdata_d   = s_axi_wdata;
          wstrb_d   = s_axi_wstrb;
          w_state_d = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_hs) begin
          wr_fire = 1'b1;
          wr_data = s_axi_wdata;
          wr_strb = s_axi_wstrb;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          wr_fire = 1'b1;
          wr_addr = s_axi_awaddr;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    if (wr_fire) begin
      w_state_d = W_RESP;
      if (addr_unmapped(wr_addr)) begin
        bresp_d = RESP_UNMAPPED;
      end else begin
        case (wr_addr[3:2])
          2'd0: begin
            ctrl_d     = merge_bytes(ctrl_q, wr_data, wr_strb);
            bresp_d    = RESP_OKAY;
            wr_count_d = wr_count_q + 1'b1;
          end
          2'd1: begin
            data_d     = merge_bytes(data_q, wr_data, wr_strb);
            bresp_d    = RESP_OKAY;
            wr_count_d = wr_count_q + 1'b1;
          end
          default: bresp_d = RESP_SLVERR;
        endcase
      end
    end
  end

  // Read channel: data sampled from the _q registers, so a write committing on
  // the same edge is not yet visible.
  always_comb begin
    r_state_d  = r_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_count_d = rd_count_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d  = R_DATA;
          rd_count_d = rd_count_q + 1'b1;
          if (addr_unmapped(s_axi_araddr)) begin
            rdata_d = '0;
            rresp_d = RESP_UNMAPPED;
          end else begin
            rresp_d = RESP_OKAY;
            case (s_axi_araddr[3:2])
              2'd0:    rdata_d = ctrl_q;
              2'd1:    rdata_d = data_q;
              2'd2:    rdata_d = wr_count_q;
              default: rdata_d = rd_count_q;
            endcase
          end
        end
      end
      R_DATA: begin
        if (s_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      active_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      ctrl_q     <= '0;
      data_q     <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      active_q   <= active_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - directed self-checking bench for axil_reg_slave
module tb_axil_reg_slave;

  logic        clk;
  logic        rst_n;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] ctrl_o;

  int checks = 0;
  int errors = 0;

`ifdef AXIL_REG_SLAVE_DECERR_EN
  localparam logic [2:0] UNMAPPED_RESP = 3'd3;
`else
  localparam logic [2:0] UNMAPPED_RESP = 3'd0;
`endif

  axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .ctrl_o        (ctrl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [2:0] r);
    int n;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("wr_bvalid_latency", {31'd0, bvalid}, 32'd1);
    r = bresp;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rd_rvalid_latency", {31'd0, rvalid}, 32'd1);
    d = rdata;
    r = rresp;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic [2:0]  resp;

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_bresp",   {29'd0, bresp},   32'd0);
    check("rst_rresp",   {29'd0, rresp},   32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_ctrl",    ctrl_o,           32'd0);
    rst_n = 1'b1;
    #1 check("rel_awready_low", {31'd0, awready}, 32'd0);
    @(posedge clk); #1;
    check("rel_awready", {31'd0, awready}, 32'd1);
    check("rel_wready",  {31'd0, wready},  32'd1);
    check("rel_arready", {31'd0, arready}, 32'd1);

    // AW and W in the same cycle to CTRL
    @(negedge clk);
    awaddr = 8'h00; awvalid = 1'b1; wdata = 32'hA5A5_1234; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t1_bvalid", {31'd0, bvalid}, 32'd1);
    check("t1_bresp",  {29'd0, bresp},  32'd0);
    check("t1_ctrl_o", ctrl_o, 32'hA5A5_1234);
    check("t1_awready_busy", {31'd0, awready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_bvalid_clear", {31'd0, bvalid}, 32'd0);
    do_read(8'h00, rd, resp);
    check("t1_rdata", rd, 32'hA5A5_1234);
    check("t1_rresp", {29'd0, resp}, 32'd0);

    // W three cycles ahead of AW, partial strobe on DATA
    do_write(8'h04, 32'h1111_1111, 4'hF, resp);
    check("t2_pre_bresp", {29'd0, resp}, 32'd0);
    @(negedge clk);
    wdata = 32'h0000_FF00; wstrb = 4'h2; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    check("t2_wready_held", {31'd0, wready}, 32'd0);
    check("t2_awready_open", {31'd0, awready}, 32'd1);
    check("t2_no_bvalid_a", {31'd0, bvalid}, 32'd0);
    @(negedge clk);
    check("t2_no_bvalid_b", {31'd0, bvalid}, 32'd0);
    @(negedge clk);
    awaddr = 8'h04; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("t2_bvalid", {31'd0, bvalid}, 32'd1);
    check("t2_bresp",  {29'd0, bresp},  32'd0);
    @(posedge clk); #1;
    do_read(8'h04, rd, resp);
    check("t2_data", rd, 32'h1111_FF11);

    // Write to RO register with B back-pressure
    @(negedge clk);
    awaddr = 8'h08; awvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_bvalid",  {31'd0, bvalid},  32'd1);
      check("t3_bresp",   {29'd0, bresp},   32'd2);
      check("t3_awready", {31'd0, awready}, 32'd0);
      check("t3_wready",  {31'd0, wready},  32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_bvalid_clear", {31'd0, bvalid}, 32'd0);
    do_read(8'h08, rd, resp);
    check("t3_wr_count", rd, 32'd3);

    // Read and write of CTRL committing on the same edge
    @(negedge clk);
    awaddr = 8'h00; awvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    araddr = 8'h00; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("same_rdata_old", rdata, 32'hA5A5_1234);
    check("same_ctrl_new", ctrl_o, 32'h0BAD_F00D);
    @(posedge clk); #1;

    // Unmapped accesses
    do_write(8'h40, 32'hDEAD_BEEF, 4'hF, resp);
    check("t5_wr_resp", {29'd0, resp}, {29'd0, UNMAPPED_RESP});
    do_read(8'h40, rd, resp);
    check("t5_rd_resp", {29'd0, resp}, {29'd0, UNMAPPED_RESP});
    check("t5_rd_data", rd, 32'd0);
    check("t5_ctrl", ctrl_o, 32'h0BAD_F00D);
    do_read(8'h04, rd, resp);
    check("t5_data", rd, 32'h1111_FF11);
    do_read(8'h08, rd, resp);
    check("t5_wr_count", rd, 32'd4);

    // Reset in W_ADDR with rvalid high
    @(negedge clk);
    awaddr = 8'h04; awvalid = 1'b1; araddr = 8'h00; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("t6_pre_wready", {31'd0, wready}, 32'd1);
    check("t6_pre_awready", {31'd0, awready}, 32'd0);
    check("t6_pre_rvalid", {31'd0, rvalid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_awready", {31'd0, awready}, 32'd0);
    check("t6_wready",  {31'd0, wready},  32'd0);
    check("t6_arready", {31'd0, arready}, 32'd0);
    check("t6_rvalid",  {31'd0, rvalid},  32'd0);
    check("t6_bvalid",  {31'd0, bvalid},  32'd0);
    check("t6_rdata",   rdata,            32'd0);
    check("t6_ctrl",    ctrl_o,           32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("t6_rel_arready_low", {31'd0, arready}, 32'd0);
    @(posedge clk); #1;
    check("t6_rel_awready", {31'd0, awready}, 32'd1);
    check("t6_rel_arready", {31'd0, arready}, 32'd1);
    check("t6_no_bvalid",   {31'd0, bvalid},  32'd0);

    // Counters from a fresh reset
    do_read(8'h0C, rd, resp);
    check("t4_rd_count0", rd, 32'd0);
    @(negedge clk);
    araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_stall_rvalid",  {31'd0, rvalid},  32'd1);
      check("t4_stall_rdata",   rdata,            32'd1);
      check("t4_stall_arready", {31'd0, arready}, 32'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_rvalid_clear", {31'd0, rvalid}, 32'd0);
    do_read(8'h04, rd, resp);
    check("t4_data_reset", rd, 32'd0);
    do_write(8'h00, 32'h1234_5678, 4'hF, resp);
    do_write(8'h04, 32'hFFFF_FFFF, 4'h0, resp);
    check("t4_strb0_resp", {29'd0, resp}, 32'd0);
    do_write(8'h00, 32'h0000_00AB, 4'h1, resp);
    do_read(8'h08, rd, resp);
    check("t4_wr_count", rd, 32'd3);
    do_read(8'h04, rd, resp);
    check("t4_strb0_data", rd, 32'd0);
    check("t4_ctrl_merge", ctrl_o, 32'h1234_56AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite register-file responder that terminates one master port of the bus interconnect (`m1_*` or `m2_*` side). It accepts single-beat writes and reads, holds two read/write registers and two read-only counters, and returns OKAY/SLVERR/DECERR responses. Write and read channels run independent state machines in one clock domain.

## Interface
- `DATA_WIDTH`, 32, data bus width; multiple of 8.
- `ADDR_WIDTH`, 8, byte address width; at least 4.
- `RESP_WIDTH`, 3, response field width; codes zero-extended (OKAY=0, SLVERR=2, DECERR=3).
- `s_axi_aclk` in 1, sole clock.
- `s_axi_aresetn` in 1, reset, asynchronous, active-low.
- `s_axi_awaddr` in ADDR_WIDTH; `s_axi_awvalid` in 1; `s_axi_awready` out 1.
- `s_axi_wdata` in DATA_WIDTH; `s_axi_wstrb` in DATA_WIDTH/8; `s_axi_wvalid` in 1; `s_axi_wready` out 1.
- `s_axi_bresp` out RESP_WIDTH; `s_axi_bvalid` out 1; `s_axi_bready` in 1.
- `s_axi_araddr` in ADDR_WIDTH; `s_axi_arvalid` in 1; `s_axi_arready` out 1.
- `s_axi_rdata` out DATA_WIDTH; `s_axi_rresp` out RESP_WIDTH; `s_axi_rvalid` out 1; `s_axi_rready` in 1.
- `ctrl_o` out DATA_WIDTH, live value of CTRL register.

## Operation
- Address decode on `addr[3:2]`; `addr[1:0]` ignored; any nonzero bit in `addr[ADDR_WIDTH-1:4]` = unmapped.
- Map: 0x0 CTRL (RW), 0x4 DATA (RW), 0x8 WR_COUNT (RO, OKAY writes completed, wraps), 0xC RD_COUNT (RO, read address handshakes accepted, wraps).
- Write to RW register: each byte lane updated only where `wstrb` bit set; bresp OKAY; WR_COUNT += 1.
- Write to RO register: no state change, bresp SLVERR, WR_COUNT unchanged.
- Read of mapped register: rresp OKAY. RD_COUNT returns its pre-increment value; increments on every AR handshake (mapped or not).
- Write FSM: W_IDLE (awready=wready=1) -> W_ADDR (address captured, awready=0, wready=1) or W_DATA (data captured, wready=0, awready=1) -> W_RESP (both ready=0, bvalid=1) -> W_IDLE on `bvalid && bready`.
- AW and W handshaking in the same cycle: W_IDLE -> W_RESP directly.
- Read FSM: R_IDLE (arready=1) -> R_DATA on AR handshake (arready=0, rvalid=1, rdata/rresp registered) -> R_IDLE on `rvalid && rready`.
- bresp/bvalid and rdata/rresp/rvalid held stable until accepted.

## Timing
- Reset values: all ready/valid outputs 0, `bresp`=`rresp`=0, `rdata`=0, CTRL=DATA=WR_COUNT=RD_COUNT=0, both FSMs idle. Ready outputs rise on the first clock edge after reset deassertion.
- Write latency: register update and `bvalid` rise on the edge completing the second of AW/W handshakes; visible the following cycle.
- Read latency: `rvalid` and data registered on the AR handshake edge; one cycle.
- Next transaction accepted no earlier than the cycle after the B (or R) handshake; one outstanding write and one outstanding read max.
- Read and write to same register completing on the same edge: read returns pre-write value.
- WR_COUNT read on the edge a write completes: returns pre-increment value.
- Reset asserted mid-transaction: outputs clear immediately (asynchronously); in-flight transaction dropped, no response issued.
- `wstrb`=0 to RW register: no bytes change, still OKAY, WR_COUNT increments.

## Configuration
- `AXIL_REG_SLAVE_DECERR_EN` defined: unmapped write returns bresp DECERR with no state change; unmapped read returns rdata 0, rresp DECERR.
- Undefined: unmapped accesses return OKAY; writes ignored (WR_COUNT unchanged), reads return 0.

## Test plan
- AW 0x00 and W 0xA5A5_1234 strb 0xF same cycle, bready=1 -> bvalid one cycle later, bresp 0; read 0x00 -> rdata 0xA5A5_1234, rresp 0; `ctrl_o` = 0xA5A5_1234.
- W 0x0000_FF00 strb 0x2 three cycles before AW 0x04 on DATA=0x1111_1111 -> DATA=0x1111_FF11, bvalid the cycle after AW handshake.
- Write 0x08, bready held low 5 cycles -> bresp 2 held stable with bvalid, awready/wready 0 throughout; WR_COUNT unchanged.
- Three OKAY writes then read 0x08 -> 3; two reads of 0x0C -> 0 then 1; rready low 4 cycles keeps rdata stable, arready 0.
- Read/write 0x40 with macro defined -> resp 3, rdata 0; without macro -> resp 0, rdata 0; CTRL/DATA unchanged either way.
- Assert reset while in W_ADDR with rvalid high -> all valids/readies 0 immediately, registers 0, readies return 1 cycle after release.
